// File: rtl/except_ctrl.sv
// Commit-stage exception controller: detects interrupts, exceptions and ERET,
// reports the event to CP0 for one cycle, then redirects the PC.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic        syscall_i,
  input  logic        ri_i,
  input  logic        trap_i,
  input  logic        ov_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        pc_we_o,
  output logic [31:0] new_pc_o,
  output logic [15:0] exc_count_o
);

  localparam logic [31:0] CODE_NONE    = 32'h00;
  localparam logic [31:0] CODE_INT     = 32'h01;
  localparam logic [31:0] CODE_SYSCALL = 32'h08;
  localparam logic [31:0] CODE_RI      = 32'h0a;
  localparam logic [31:0] CODE_TRAP    = 32'h0d;
  localparam logic [31:0] CODE_OV      = 32'h0c;
  localparam logic [31:0] CODE_ERET    = 32'h0e;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TAKE     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] cap_target;

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pending;
  logic [31:0] sel_code;
  logic [31:0] sel_target;

  // Forward the committing instruction's own CP0 write so a same-cycle
  // mtc0 affects detection (only the software-interrupt bits of Cause are writable).
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (cp0_we_i && cp0_waddr_i == ADDR_STATUS) eff_status = cp0_wdata_i;
    if (cp0_we_i && cp0_waddr_i == ADDR_CAUSE)  eff_cause[9:8] = cp0_wdata_i[9:8];
    if (cp0_we_i && cp0_waddr_i == ADDR_EPC)    eff_epc = cp0_wdata_i;
  end

  assign int_pending = ((eff_status & 32'h0000_0003) == 32'h0000_0001) &&
                       ((eff_cause & eff_status & 32'h0000_FF00) != 32'h0);

  // NOTE: every variable in this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_code   = CODE_NONE;
    sel_target = EXC_VECTOR;
    if (int_pending)    sel_code = CODE_INT;
    else if (syscall_i) sel_code = CODE_SYSCALL;
    else if (ri_i)      sel_code = CODE_RI;
    else if (trap_i)    sel_code = CODE_TRAP;
    else if (ov_i)      sel_code = CODE_OV;
    else if (eret_i) begin
      sel_code   = CODE_ERET;
      sel_target = eff_epc;
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state               <= IDLE;
      cap_target          <= 32'h0;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      flush_o             <= 1'b0;
      stall_o             <= 1'b0;
      pc_we_o             <= 1'b0;
      new_pc_o            <= 32'h0;
      exc_count_o         <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_valid_i && sel_code != CODE_NONE) begin
            state               <= TAKE;
            cap_target          <= sel_target;
            excepttype_o        <= sel_code;
            current_inst_addr_o <= inst_addr_i;
            is_in_delayslot_o   <= in_delayslot_i;
            flush_o             <= 1'b1;
            stall_o             <= 1'b1;
            exc_count_o         <= exc_count_o + 16'h1;
          end
        end
        TAKE: begin
          state               <= REDIRECT;
          excepttype_o        <= 32'h0;
          current_inst_addr_o <= 32'h0;
          is_in_delayslot_o   <= 1'b0;
          flush_o             <= 1'b0;
          stall_o             <= 1'b1;
          pc_we_o             <= 1'b1;
          new_pc_o            <= cap_target;
        end
        REDIRECT: begin
          state    <= IDLE;
          stall_o  <= 1'b0;
          pc_we_o  <= 1'b0;
          new_pc_o <= 32'h0;
        end
        default: begin
          state               <= IDLE;
          excepttype_o        <= 32'h0;
          current_inst_addr_o <= 32'h0;
          is_in_delayslot_o   <= 1'b0;
          flush_o             <= 1'b0;
          stall_o             <= 1'b0;
          pc_we_o             <= 1'b0;
          new_pc_o            <= 32'h0;
        end
      endcase
    end
  end

endmodule
